// File: rtl/mem_pkg.sv
// Definitions shared by the memory arbiter, the LSB and the byte-serial memory controller.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IC_BUSY,
    ST_LSB_BUSY,
    ST_IO_WAIT,
    ST_GAP
  } arb_state_e;

  typedef enum logic [2:0] {
    INSTY_LB  = 3'd0,
    INSTY_LH  = 3'd1,
    INSTY_LW  = 3'd2,
    INSTY_LBU = 3'd3,
    INSTY_LHU = 3'd4,
    INSTY_SB  = 3'd5,
    INSTY_SH  = 3'd6,
    INSTY_SW  = 3'd7
  } insty_e;

  localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

  function automatic logic is_store(input logic [2:0] insty);
    return insty inside {INSTY_SB, INSTY_SH, INSTY_SW};
  endfunction

  function automatic logic is_io(input logic [31:0] addr, input logic [1:0] io_sel = IO_SEL_DEFAULT);
    return addr[17:16] == io_sel;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the two memory requesters, the arbiter and the memory controller.
interface mem_arbiter_if;

  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_done;
  logic [31:0] ic_data;

  logic        lsb_req;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic [2:0]  lsb_insty;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  logic        mc_ic_valid;
  logic [31:0] mc_ic_addr;
  logic        mc_ic_done;
  logic [31:0] mc_ic_data;

  logic        mc_lsb_valid;
  logic [31:0] mc_lsb_addr;
  logic [31:0] mc_lsb_wdata;
  logic [2:0]  mc_lsb_insty;
  logic        mc_lsb_done;
  logic [31:0] mc_lsb_data;

  // The arbiter sits on the slave side: it serves requesters and issues controller requests.
  modport slave (
    input  ic_req, ic_addr, lsb_req, lsb_addr, lsb_wdata, lsb_insty,
    input  mc_ic_done, mc_ic_data, mc_lsb_done, mc_lsb_data,
    output ic_done, ic_data, lsb_done, lsb_rdata,
    output mc_ic_valid, mc_ic_addr, mc_lsb_valid, mc_lsb_addr, mc_lsb_wdata, mc_lsb_insty
  );

  modport master (
    output ic_req, ic_addr, lsb_req, lsb_addr, lsb_wdata, lsb_insty,
    output mc_ic_done, mc_ic_data, mc_lsb_done, mc_lsb_data,
    input  ic_done, ic_data, lsb_done, lsb_rdata,
    input  mc_ic_valid, mc_ic_addr, mc_lsb_valid, mc_lsb_addr, mc_lsb_wdata, mc_lsb_insty
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant decision: LSB wins unless the ICache has waited through STARVE_MAX consecutive LSB grants.
module mem_arb_pick #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             ic_req,
  input  logic             lsb_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_ic,
  output logic             grant_lsb
);

  always_comb begin
    grant_lsb = lsb_req && ((starve_cnt < CNT_W'(STARVE_MAX)) || !ic_req);
    grant_ic  = ic_req && !grant_lsb;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Transaction-level arbiter between ICache refill and LSB in front of the byte-serial memory controller.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int         STARVE_MAX = 4,
  parameter logic [1:0] IO_SEL     = IO_SEL_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  input  logic          jp_wrong,
  input  logic          io_buffer_full,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_ic;
  logic             grant_lsb;
  logic             take_ic;
  logic             take_lsb;
  logic             lsb_to_io;
  logic             held_store;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
    .ic_req     (bus.ic_req),
    .lsb_req    (bus.lsb_req),
    .starve_cnt (starve_cnt),
    .grant_ic   (grant_ic),
    .grant_lsb  (grant_lsb)
  );

  assign take_lsb   = (state == ST_IDLE) && !jp_wrong && grant_lsb;
  assign take_ic    = (state == ST_IDLE) && !jp_wrong && grant_ic;
  assign lsb_to_io  = is_store(bus.lsb_insty) && is_io(bus.lsb_addr, IO_SEL) && io_buffer_full;
  // A latched store has already committed, so a mispredict flush must not drop it.
  assign held_store = is_store(bus.mc_lsb_insty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (rdy) begin
      if (!bus.ic_req || take_ic) begin
        starve_cnt <= '0;
      end else if (take_lsb && (starve_cnt < CNT_W'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      bus.mc_ic_valid  <= 1'b0;
      bus.mc_ic_addr   <= '0;
      bus.mc_lsb_valid <= 1'b0;
      bus.mc_lsb_addr  <= '0;
      bus.mc_lsb_wdata <= '0;
      bus.mc_lsb_insty <= '0;
      bus.ic_done      <= 1'b0;
      bus.ic_data      <= '0;
      bus.lsb_done     <= 1'b0;
      bus.lsb_rdata    <= '0;
    end else if (rdy) begin
      bus.ic_done  <= 1'b0;
      bus.lsb_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (take_lsb) begin
            bus.mc_lsb_addr  <= bus.lsb_addr;
            bus.mc_lsb_wdata <= bus.lsb_wdata;
            bus.mc_lsb_insty <= bus.lsb_insty;
            bus.mc_lsb_valid <= !lsb_to_io;
            state            <= lsb_to_io ? ST_IO_WAIT : ST_LSB_BUSY;
          end else if (take_ic) begin
            bus.mc_ic_addr  <= bus.ic_addr;
            bus.mc_ic_valid <= 1'b1;
            state           <= ST_IC_BUSY;
          end
        end
        ST_IC_BUSY: begin
          if (jp_wrong) begin
            bus.mc_ic_valid <= 1'b0;
            state           <= ST_IDLE;
          end else if (bus.mc_ic_done) begin
            bus.mc_ic_valid <= 1'b0;
            bus.ic_done     <= 1'b1;
            bus.ic_data     <= bus.mc_ic_data;
            state           <= ST_GAP;
          end
        end
        ST_LSB_BUSY: begin
          if (jp_wrong && !held_store) begin
            bus.mc_lsb_valid <= 1'b0;
            state            <= ST_IDLE;
          end else if (bus.mc_lsb_done) begin
            bus.mc_lsb_valid <= 1'b0;
            bus.lsb_done     <= 1'b1;
            bus.lsb_rdata    <= bus.mc_lsb_data;
            state            <= ST_GAP;
          end
        end
        ST_IO_WAIT: begin
          if (jp_wrong && !held_store) begin
            state <= ST_IDLE;
          end else if (!io_buffer_full) begin
            bus.mc_lsb_valid <= 1'b1;
            state            <= ST_LSB_BUSY;
          end
        end
        // One dead cycle so the controller can clear its byte-step counters.
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Transaction-level scheduler between the two memory requesters (ICache refill, LSB load/store) and the byte-serial memory controller. Grants the controller to one requester at a time, holds the grant stable for the whole transaction, and bounds ICache starvation under heavy LSB traffic. Handles branch-mispredict flushes and I/O-region throttling so the controller only ever sees clean, non-overlapping requests.

## Interface
- `STARVE_MAX`, 4: max consecutive LSB grants while `ic_req` is pending before the IC is forced.
- `IO_SEL`, 2'b11: value of `addr[17:16]` that marks the I/O region.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `rdy`  in  1  global enable; low freezes all state
- `jp_wrong`  in  1  mispredict flush pulse
- `io_buffer_full`  in  1  UART buffer full
- `ic_req`  in  1  IC fetch request, level, held until `ic_done`
- `ic_addr`  in  32  IC fetch address
- `ic_done`  out  1  one-cycle completion pulse
- `ic_data`  out  32  fetched word, valid with `ic_done`
- `lsb_req`  in  1  LSB request, level, held until `lsb_done`
- `lsb_addr`  in  32  LSB address
- `lsb_wdata`  in  32  store data
- `lsb_insty`  in  3  access type, codes LB/LH/LW/LBU/LHU/SB/SH/SW
- `lsb_done`  out  1  one-cycle completion pulse
- `lsb_rdata`  out  32  load result, valid with `lsb_done`
- `mc_ic_valid`, `mc_ic_addr`  out  1/32  IC-side request to controller
- `mc_ic_done`, `mc_ic_data`  in  1/32  controller IC completion
- `mc_lsb_valid`, `mc_lsb_addr`, `mc_lsb_wdata`, `mc_lsb_insty`  out  1/32/32/3  LSB-side request to controller
- `mc_lsb_done`, `mc_lsb_data`  in  1/32  controller LSB completion

## Operation
- States: IDLE, IC_BUSY, LSB_BUSY, IO_WAIT, GAP.
- IDLE arbitration, evaluated only when `rdy` and not `jp_wrong`:
  - if `lsb_req` and (`starve_cnt < STARVE_MAX` or !`ic_req`), grant LSB;
  - else if `ic_req`, grant IC.
- On grant, latch the request (address, data, type) into registers. Controller-side outputs are driven only from these latched copies.
- LSB grant target state: IO_WAIT if the access is a store with `addr[17:16]==IO_SEL` and `io_buffer_full`; LSB_BUSY otherwise.
- IO_WAIT holds `mc_lsb_valid`=0. It moves to LSB_BUSY on the first cycle `io_buffer_full`=0.
- `starve_cnt` (saturating at `STARVE_MAX`):
  - +1 on each LSB grant while `ic_req`=1;
  - cleared on an IC grant, or when `ic_req`=0.
- IC_BUSY → GAP on `mc_ic_done`: pulse `ic_done`, register `ic_data`.
- LSB_BUSY → GAP on `mc_lsb_done`: pulse `lsb_done`, register `lsb_rdata`.
- GAP: one idle cycle with both `mc_*_valid`=0, so the controller clears its byte-step counters. Then return to IDLE.
- Flush (`jp_wrong`=1):
  - IC_BUSY → IDLE; no `ic_done`.
  - LSB_BUSY/IO_WAIT holding a load → IDLE; no `lsb_done`.
  - LSB_BUSY/IO_WAIT holding a store: unaffected, runs to completion (store already committed).
  - IDLE: no grant that cycle.
  - GAP: unaffected.
- `rdy`=0: no state, counter or output register changes.

## Timing
- Reset: state IDLE, `starve_cnt`=0, all valid/done outputs 0, all data/address outputs 0.
- Grant latency: request seen in IDLE at edge N → `mc_*_valid`=1 after edge N.
- Completion: `mc_*_done` at edge M → `*_done`=1 for exactly the cycle after edge M; `mc_*_valid` drops at the same edge.
- Minimum turnaround: done → GAP → IDLE → next valid. That is 3 edges between the done edge and the next valid.
- `mc_ic_valid` and `mc_lsb_valid` are never 1 together.
- Flush abort: `mc_*_valid` is 0 after the `jp_wrong` edge.
- Done and flush in the same cycle on a load or IC request: the flush wins, no done pulse.
- Reset mid-transaction: immediate return to the reset values; controller valids drop asynchronously.

## Structure
- `mem_pkg`: state enum, `lsb_insty` codes, `is_store(insty)`, `is_io(addr)` helpers. These are shared with the LSB and the controller.
- Sub-module `mem_arb_pick`: combinational grant decision from (`ic_req`, `lsb_req`, `starve_cnt`). The FSM and latches stay in the top.

## Test plan
- `ic_req` alone, addr 0x100; controller done after 4 cycles with 0xDEADBEEF → `ic_done` pulse 1 cycle, `ic_data`=0xDEADBEEF, GAP observed.
- `ic_req` and `lsb_req` (LW) asserted continuously, `STARVE_MAX`=4 → grant pattern LSB×4, IC, LSB×4, IC…; the two `mc_*_valid` are never high together.
- SW to 0x30000 with `io_buffer_full`=1 for 5 cycles → `mc_lsb_valid` stays 0 for those 5 cycles, rises the cycle after full drops, then `lsb_done` follows.
- `jp_wrong` during an IC fetch and during an LW → both aborted, no done pulses, back to IDLE next cycle. `jp_wrong` during an SB → `lsb_done` still delivered.
- `rdy`=0 for 3 cycles mid-LSB_BUSY → all outputs frozen, and the transaction completes normally after `rdy` returns.
- Assert `rst_n`=0 mid-transaction → all outputs 0 immediately, `starve_cnt`=0, and normal operation resumes after release.
